// File: rtl/stream_packer.sv
// Width-converting packer: gathers BEATS narrow beats (little-endian) into one wide word,
// with early close on in_last, an assembly register and an output register for full throughput.
module stream_packer #(
  parameter int DATA_WIDTH = 8,
  parameter int BEATS      = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DATA_WIDTH-1:0]         in_data,
  input  logic                          in_valid,
  input  logic                          in_last,
  output logic                          in_ready,
  output logic [DATA_WIDTH*BEATS-1:0]   out_data,
  output logic [BEATS-1:0]              out_keep,
  output logic                          out_last,
  output logic                          out_valid,
  input  logic                          out_ready
);

  localparam int CW = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int WW = DATA_WIDTH * BEATS;
  localparam logic [CW-1:0] LAST_SLOT = CW'(BEATS - 1);

  logic [WW-1:0]    asmData_q, asmData_d;
  logic [BEATS-1:0] asmKeep_q, asmKeep_d;
  logic             asmLast_q, asmLast_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             done_q, done_d;
  logic [WW-1:0]    outData_q, outData_d;
  logic [BEATS-1:0] outKeep_q, outKeep_d;
  logic             outLast_q, outLast_d;
  logic             outValid_q, outValid_d;

  logic             slotFree;
  logic             accept;
  logic             complete;
  logic             loadOut;
  logic [WW-1:0]    wordData;
  logic [BEATS-1:0] wordKeep;

  // in_ready depends only on the done register (plus reset), never on out_ready.
  assign in_ready  = rst && !done_q;
  assign out_data  = outData_q;
  assign out_keep  = outKeep_q;
  assign out_last  = outLast_q;
  assign out_valid = outValid_q;

  always_comb begin
    slotFree   = !outValid_q || out_ready;
    accept     = in_valid && in_ready;
    complete   = accept && ((cnt_q == LAST_SLOT) || in_last);
    wordData   = asmData_q;
    wordKeep   = asmKeep_q;
    loadOut    = 1'b0;
    asmData_d  = asmData_q;
    asmKeep_d  = asmKeep_q;
    asmLast_d  = asmLast_q;
    cnt_d      = cnt_q;
    done_d     = done_q;
    outData_d  = outData_q;
    outKeep_d  = outKeep_q;
    outLast_d  = outLast_q;
    outValid_d = outValid_q;

    for (int k = 0; k < BEATS; k++) begin
      if (cnt_q == CW'(k)) begin
        wordData[k*DATA_WIDTH +: DATA_WIDTH] = in_data;
        wordKeep[k] = 1'b1;
      end
    end

    // A held (done) word has priority; no beat can be accepted while done is set.
    if (done_q) begin
      if (slotFree) begin
        loadOut   = 1'b1;
        outData_d = asmData_q;
        outKeep_d = asmKeep_q;
        outLast_d = asmLast_q;
        asmData_d = '0;
        asmKeep_d = '0;
        asmLast_d = 1'b0;
        cnt_d     = '0;
        done_d    = 1'b0;
      end
    end else if (complete) begin
      if (slotFree) begin
        loadOut   = 1'b1;
        outData_d = wordData;
        outKeep_d = wordKeep;
        outLast_d = in_last;
        asmData_d = '0;
        asmKeep_d = '0;
        asmLast_d = 1'b0;
        cnt_d     = '0;
      end else begin
        asmData_d = wordData;
        asmKeep_d = wordKeep;
        asmLast_d = in_last;
        done_d    = 1'b1;
      end
    end else if (accept) begin
      asmData_d = wordData;
      asmKeep_d = wordKeep;
      cnt_d     = cnt_q + CW'(1);
    end

    if (loadOut) begin
      outValid_d = 1'b1;
    end else if (out_ready) begin
      outValid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      asmData_q  <= '0;
      asmKeep_q  <= '0;
      asmLast_q  <= 1'b0;
      cnt_q      <= '0;
      done_q     <= 1'b0;
      outData_q  <= '0;
      outKeep_q  <= '0;
      outLast_q  <= 1'b0;
      outValid_q <= 1'b0;
    end else begin
      asmData_q  <= asmData_d;
      asmKeep_q  <= asmKeep_d;
      asmLast_q  <= asmLast_d;
      cnt_q      <= cnt_d;
      done_q     <= done_d;
      outData_q  <= outData_d;
      outKeep_q  <= outKeep_d;
      outLast_q  <= outLast_d;
      outValid_q <= outValid_d;
    end
  end

endmodule

// File: tb/tb_stream_packer.sv
// Self-checking bench for stream_packer: directed scenarios plus randomized traffic
// compared every cycle against a queue-based reference model.
module tb_stream_packer;

  localparam int DW = 8;
  localparam int NB = 4;
  localparam int WW = DW * NB;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_valid = 1'b0;
  logic          in_last = 1'b0;
  logic          in_ready;
  logic [WW-1:0] out_data;
  logic [NB-1:0] out_keep;
  logic          out_last;
  logic          out_valid;
  logic          out_ready = 1'b0;

  typedef struct {
    logic [WW-1:0] data;
    logic [NB-1:0] keep;
    logic          last;
  } word_t;

  typedef struct {
    logic [DW-1:0] d;
    logic          l;
  } beat_t;

  word_t         wordQ[$];
  logic [DW-1:0] curBeats[$];
  beat_t         beatQ[$];
  logic [WW-1:0] obsLog[$];
  bit            cleanReset = 1'b1;
  bit            accFlag = 1'b0;
  int            checkCount = 0;
  int            errorCount = 0;
  int            dutAccepts = 0;
  int            readyLows = 0;

  stream_packer #(.DATA_WIDTH(DW), .BEATS(NB)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_keep  (out_keep),
    .out_last  (out_last),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  // Reference model: words in flight form a queue (head = output register); at most two fit.
  always @(posedge clk) begin
    bit    take;
    bit    acc;
    word_t w;
    if (!rst) begin
      curBeats.delete();
      wordQ.delete();
      cleanReset = 1'b1;
      accFlag    = 1'b0;
    end else begin
      take = out_ready && (wordQ.size() > 0);
      acc  = in_valid && (wordQ.size() < 2);
      if (take) void'(wordQ.pop_front());
      if (acc) begin
        curBeats.push_back(in_data);
        if (curBeats.size() == NB || in_last) begin
          w.data = '0;
          for (int k = 0; k < curBeats.size(); k++)
            w.data = w.data | (WW'(curBeats[k]) << (k * DW));
          w.keep = NB'((1 << curBeats.size()) - 1);
          w.last = in_last;
          wordQ.push_back(w);
          curBeats.delete();
          cleanReset = 1'b0;
        end
      end
      accFlag = acc;
    end
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checkCount++;
    if (obs !== exp) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic compareAll();
    checkOutput("in_ready", 64'(in_ready), 64'(rst && (wordQ.size() < 2)));
    checkOutput("out_valid", 64'(out_valid), 64'(wordQ.size() > 0));
    if (wordQ.size() > 0) begin
      checkOutput("out_data", 64'(out_data), 64'(wordQ[0].data));
      checkOutput("out_keep", 64'(out_keep), 64'(wordQ[0].keep));
      checkOutput("out_last", 64'(out_last), 64'(wordQ[0].last));
    end else if (cleanReset) begin
      checkOutput("rst_data", 64'(out_data), 64'd0);
      checkOutput("rst_keep", 64'(out_keep), 64'd0);
      checkOutput("rst_last", 64'(out_last), 64'd0);
    end
  endtask

  // One cycle: check outputs at the falling edge, then drive the next inputs.
  task automatic applyStimulus(input logic v, input logic [DW-1:0] d, input logic l,
                               input logic ordy, input logic r);
    @(negedge clk);
    compareAll();
    in_valid  = v;
    in_data   = d;
    in_last   = l;
    out_ready = ordy;
    rst       = r;
    #1;
    if (v && in_ready) dutAccepts++;
    if (r && !in_ready) readyLows++;
    if (out_valid && ordy) obsLog.push_back(out_data);
  endtask

  task automatic runBeats(input logic ordy, input int maxCycles);
    int n = 0;
    while (beatQ.size() > 0 && n < maxCycles) begin
      applyStimulus(1'b1, beatQ[0].d, beatQ[0].l, ordy, 1'b1);
      @(posedge clk);
      #1;
      if (accFlag) void'(beatQ.pop_front());
      n++;
    end
  endtask

  task automatic idle(input logic ordy, input int n);
    repeat (n) applyStimulus(1'b0, '0, 1'b0, ordy, 1'b1);
  endtask

  task automatic addBeat(input logic [DW-1:0] d, input logic l);
    beat_t b;
    b.d = d;
    b.l = l;
    beatQ.push_back(b);
  endtask

  task automatic checkLog(input string tag, input int idx, input logic [WW-1:0] exp);
    logic [WW-1:0] got;
    got = (idx < obsLog.size()) ? obsLog[idx] : 'x;
    checkOutput(tag, 64'(got), 64'(exp));
  endtask

  initial begin
    repeat (3) @(negedge clk);
    applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, '0, 1'b0, 1'b1, 1'b1);

    // Full word
    obsLog.delete();
    addBeat(8'h11, 1'b0); addBeat(8'h22, 1'b0); addBeat(8'h33, 1'b0); addBeat(8'h44, 1'b0);
    runBeats(1'b1, 20);
    idle(1'b1, 3);
    checkOutput("full_count", 64'(obsLog.size()), 64'd1);
    checkLog("full_word", 0, 32'h44332211);

    // Partial words
    obsLog.delete();
    addBeat(8'hAA, 1'b0); addBeat(8'hBB, 1'b1); addBeat(8'hCC, 1'b1);
    runBeats(1'b1, 20);
    idle(1'b1, 3);
    checkLog("partial_2", 0, 32'h0000BBAA);
    checkLog("partial_1", 1, 32'h000000CC);

    // Backpressure
    obsLog.delete();
    dutAccepts = 0;
    for (int i = 1; i <= 12; i++) addBeat(DW'(i), 1'b0);
    runBeats(1'b0, 14);
    checkOutput("bp_accepts", 64'(dutAccepts), 64'd8);
    checkOutput("bp_stalled", 64'(beatQ.size()), 64'd4);
    checkOutput("bp_hold", 64'(out_data), 64'h04030201);
    runBeats(1'b1, 30);
    idle(1'b1, 4);
    checkLog("bp_word0", 0, 32'h04030201);
    checkLog("bp_word1", 1, 32'h08070605);
    checkLog("bp_word2", 2, 32'h0C0B0A09);

    // Full throughput
    obsLog.delete();
    readyLows = 0;
    for (int i = 0; i < 16; i++) addBeat(DW'(i), 1'b0);
    runBeats(1'b1, 16);
    checkOutput("tput_left", 64'(beatQ.size()), 64'd0);
    idle(1'b1, 3);
    checkOutput("tput_words", 64'(obsLog.size()), 64'd4);
    checkOutput("tput_ready_lows", 64'(readyLows), 64'd0);
    checkLog("tput_word3", 3, 32'h0F0E0D0C);

    // Reset mid-word
    addBeat(8'h55, 1'b0); addBeat(8'h66, 1'b0);
    runBeats(1'b1, 5);
    applyStimulus(1'b0, '0, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, '0, 1'b0, 1'b1, 1'b1);
    obsLog.delete();
    addBeat(8'h11, 1'b0); addBeat(8'h22, 1'b0); addBeat(8'h33, 1'b0); addBeat(8'h44, 1'b0);
    runBeats(1'b1, 20);
    idle(1'b1, 3);
    checkOutput("rst_count", 64'(obsLog.size()), 64'd1);
    checkLog("rst_word", 0, 32'h44332211);

    // Randomised stalls
    for (int i = 0; i < 2000; i++)
      applyStimulus($urandom_range(0, 99) < 60, DW'($urandom), $urandom_range(0, 5) == 0,
                    $urandom_range(0, 99) < 65, 1'b1);
    idle(1'b1, 6);
    @(negedge clk);
    compareAll();

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
